// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_unit_pkg;

    localparam int          INSTR_W          = 16;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [15:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic               req;
    logic [15:0]        addr;
    logic               ready;
    logic [INSTR_W-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rdata
    );

endinterface

// File: rtl/fetch_buf.sv
// Two-entry {pc, instr} FIFO between fetch and decode; flush wins over push/pop.
module fetch_buf
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic [1:0]   count
);
    fetch_entry_t entry_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         pop_ok;
    logic         push_ok;

    // A push into a full buffer is accepted only when the head leaves in the same edge.
    assign pop_ok  = pop && (count_q != 2'd0);
    assign push_ok = push && ((count_q != 2'd2) || pop_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                entry_q[wr_ptr_q] <= push_data;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    assign head  = entry_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/rca_16b.sv
// 16-bit ripple-carry adder; carry out of the MSB is not needed by its users.
module rca_16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum
);
    logic [15:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ carry[i];
        if (i < 15) begin : g_carry
            assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, issues imem requests, buffers results for decode.
//   state     | meaning
//   ST_RUN    | fetching; redirects and completions update pc and the buffer
//   ST_HALTED | stopped until reset; only an outstanding request is allowed to finish
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    fetch_unit_if.master       imem,
    input  logic               redirect_valid,
    input  logic [15:0]        redirect_pc,
    input  logic               stall,
    input  logic               halt,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [15:0]        instr_pc,
    output logic [15:0]        instr_pc_plus2,
    output logic               halted
);
    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  addr_q, addr_d;
    logic         req_q, req_d;
    logic         drop_q, drop_d;

    logic         complete;
    logic         hold;
    logic         flush;
    logic         push;
    logic         pop;
    logic [1:0]   count_after;
    logic [1:0]   buf_count;
    fetch_entry_t buf_head;
    fetch_entry_t push_entry;
    logic [15:0]  pc_plus2;
    logic [15:0]  head_pc_plus2;

    rca_16b u_pc_inc (
        .a   (pc_q),
        .b   (16'd2),
        .cin (1'b0),
        .sum (pc_plus2)
    );

    rca_16b u_link_inc (
        .a   (buf_head.pc),
        .b   (16'd2),
        .cin (1'b0),
        .sum (head_pc_plus2)
    );

    fetch_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .pop       (pop),
        .push_data (push_entry),
        .head      (buf_head),
        .count     (buf_count)
    );

    assign complete   = req_q && imem.ready;
    assign hold       = req_q && !imem.ready;
    assign push_entry = '{pc: addr_q, instr: imem.rdata};
    assign pop        = instr_valid && !stall;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        req_d       = req_q;
        drop_d      = drop_q;
        flush       = 1'b0;
        push        = 1'b0;
        count_after = buf_count;

        case (state_q)
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALTED;
                    flush   = 1'b1;
                    req_d   = hold;
                    drop_d  = 1'b0;
                end else if (redirect_valid) begin
                    flush  = 1'b1;
                    pc_d   = redirect_pc;
                    // An unfinished request keeps its address; its data is thrown away later.
                    drop_d = hold;
                    req_d  = 1'b1;
                    if (!hold) begin
                        addr_d = redirect_pc;
                    end
                end else begin
                    if (complete) begin
                        drop_d = 1'b0;
                        if (!drop_q) begin
                            push = 1'b1;
                            pc_d = pc_plus2;
                        end
                    end
                    count_after = buf_count + {1'b0, push} - {1'b0, pop};
                    if (hold) begin
                        req_d = 1'b1;
                    end else if (count_after < 2'd2) begin
                        req_d  = 1'b1;
                        addr_d = pc_d;
                    end else begin
                        req_d = 1'b0;
                    end
                end
            end
            ST_HALTED: begin
                req_d  = hold;
                drop_d = 1'b0;
            end
            default: begin
                state_d = ST_HALTED;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            drop_q  <= drop_d;
        end
    end

    assign imem.req  = req_q;
    assign imem.addr = addr_q;

    // Decode-facing fields read as zero whenever nothing is buffered.
    assign instr_valid    = (buf_count != 2'd0);
    assign instr          = instr_valid ? buf_head.instr : '0;
    assign instr_pc       = instr_valid ? buf_head.pc : '0;
    assign instr_pc_plus2 = instr_valid ? head_pc_plus2 : '0;
    assign halted         = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios feed an expected queue, a negedge monitor checks decode output.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] instr_pc_plus2;
    logic        halted;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int lat = 0;
    int cyc = 0;
    logic req_s;
    logic rdy_s;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ins;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [15:0] mon_p2;

    always #5 clk = ~clk;

    fetch_unit_if imem();

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .halt           (halt),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus2 (instr_pc_plus2),
        .halted         (halted)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    // Memory: ready after 'lat' extra cycles of a held request (lat=0 is zero-wait).
    assign imem.rdata = mem_word(imem.addr);
    always @(posedge clk) begin
        req_s = imem.req;
        rdy_s = imem.ready;
        #1;
        if (!rst || !imem.req) cyc = 0;
        else if (req_s && !rdy_s) cyc = cyc + 1;
        else cyc = 0;
        imem.ready = rst && imem.req && (cyc >= lat);
    end

    always @(negedge clk) begin
        if (rst && instr_valid && !stall) begin
            acc_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, required no instruction", instr_pc, instr);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_p2 = mon_e.pc + 16'd2;
                if (instr_pc !== mon_e.pc || instr !== mon_e.ins || instr_pc_plus2 !== mon_p2) begin
                    errors++;
                    $display("FAIL sb_instr: got pc=%h instr=%h pc2=%h, required pc=%h instr=%h pc2=%h",
                             instr_pc, instr, instr_pc_plus2, mon_e.pc, mon_e.ins, mon_p2);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [15:0] pc);
        exp_t e;
        e.pc  = pc;
        e.ins = mem_word(pc);
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int l);
        lat            = l;
        rst            = 1'b0;
        stall          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        exp_q.delete();
        step();
        chk1("rst_req", imem.req, 1'b0);
        chk("rst_addr", imem.addr, 16'h0000);
        chk1("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_instr_pc", instr_pc, 16'h0000);
        chk("rst_pc_plus2", instr_pc_plus2, 16'h0000);
        chk1("rst_halted", halted, 1'b0);
        step();
        acc_cnt = 0;
        rst     = 1'b1;
    endtask

    task automatic wait_acc(input int target, input int budget);
        int n = 0;
        while (acc_cnt < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (acc_cnt < target) begin
            errors++;
            $display("FAIL wait_acc: got %0d accepted, required %0d", acc_cnt, target);
        end
    endtask

    task automatic end_scenario(input string name);
        step();
        stall = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_queue_left: got %0d pending, required 0", name, exp_q.size());
        end
    endtask

    initial begin
        // Zero-wait memory: one request and one instruction per cycle.
        do_reset(0);
        for (int i = 0; i < 5; i++) push_exp(16'(2 * i));
        step();
        chk1("zw_req0", imem.req, 1'b1);
        chk("zw_addr0", imem.addr, 16'h0000);
        step();
        chk("zw_addr1", imem.addr, 16'h0002);
        chk1("zw_valid1", instr_valid, 1'b1);
        step();
        chk("zw_addr2", imem.addr, 16'h0004);
        chk1("zw_req2", imem.req, 1'b1);
        step();
        chk("zw_addr3", imem.addr, 16'h0006);
        wait_acc(5, 50);
        end_scenario("zw");

        // Stall backpressure: head held, requests stop at two buffered entries.
        do_reset(0);
        for (int i = 0; i < 6; i++) push_exp(16'(2 * i));
        step();
        step();
        stall = 1'b1;
        chk1("st_valid", instr_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk1("st_req_off", imem.req, 1'b0);
            chk("st_hold_pc", instr_pc, 16'h0000);
            chk("st_hold_instr", instr, mem_word(16'h0000));
        end
        stall = 1'b0;
        wait_acc(6, 50);
        end_scenario("st");

        // Redirect while a 3-cycle request is outstanding.
        do_reset(2);
        push_exp(16'h0040); push_exp(16'h0042); push_exp(16'h0044);
        step();
        chk("rd_addr0", imem.addr, 16'h0000);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        step();
        redirect_valid = 1'b0;
        chk("rd_addr_stable", imem.addr, 16'h0000);
        chk1("rd_req_held", imem.req, 1'b1);
        chk1("rd_valid_off", instr_valid, 1'b0);
        step();
        chk("rd_new_addr", imem.addr, 16'h0040);
        chk1("rd_new_req", imem.req, 1'b1);
        wait_acc(3, 60);
        end_scenario("rd");

        // Redirect in the same cycle the memory completes: no drop cycle.
        do_reset(2);
        push_exp(16'h0040); push_exp(16'h0042); push_exp(16'h0044);
        step();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        step();
        redirect_valid = 1'b0;
        chk("rc_new_addr", imem.addr, 16'h0040);
        chk1("rc_valid_off", instr_valid, 1'b0);
        step();
        step();
        step();
        chk1("rc_first_valid", instr_valid, 1'b1);
        chk("rc_first_pc", instr_pc, 16'h0040);
        wait_acc(3, 60);
        end_scenario("rc");

        // PC wrap-around at 16'hFFFE.
        do_reset(0);
        stall = 1'b1;
        push_exp(16'hFFFE); push_exp(16'h0000); push_exp(16'h0002);
        step();
        step();
        step();
        chk1("wr_full_req", imem.req, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        step();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        chk("wr_addr_top", imem.addr, 16'hFFFE);
        step();
        chk("wr_addr_wrap", imem.addr, 16'h0000);
        chk("wr_instr_pc", instr_pc, 16'hFFFE);
        chk("wr_pc_plus2", instr_pc_plus2, 16'h0000);
        wait_acc(3, 50);
        end_scenario("wr");

        // Halt with an outstanding request, then recovery by reset.
        do_reset(2);
        push_exp(16'h0000);
        step(); step(); step(); step();
        chk1("ht_pre_valid", instr_valid, 1'b1);
        chk("ht_pre_addr", imem.addr, 16'h0002);
        step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk1("ht_halted", halted, 1'b1);
        chk1("ht_valid_off", instr_valid, 1'b0);
        chk1("ht_req_held", imem.req, 1'b1);
        step();
        chk1("ht_req_done", imem.req, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("ht_req_stays_off", imem.req, 1'b0);
            chk1("ht_still_halted", halted, 1'b1);
            chk1("ht_still_empty", instr_valid, 1'b0);
        end
        redirect_valid = 1'b0;
        end_scenario("ht");
        do_reset(0);
        push_exp(16'h0000); push_exp(16'h0002);
        step();
        chk1("ht_restart_req", imem.req, 1'b1);
        chk("ht_restart_addr", imem.addr, 16'h0000);
        wait_acc(2, 50);
        end_scenario("hr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
